// File: rtl/sim_read_sequencer.sv
// Sequences one Main_SIM read: power-off guard, enable, timed wait with retry,
// 160-bit capture and status reporting. Optional auto-poll under SIM_SEQ_POLL_EN.
module sim_read_sequencer #(
  parameter int GUARD_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRY      = 2,
  parameter int POLL_CYCLES    = 50000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   dw_in,
`ifdef SIM_SEQ_POLL_EN
  input  logic         poll_en,
`endif
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code,
  output logic [2:0]   retry_cnt,
  output logic         data_valid,
  output logic [159:0] data_out,
  output logic         sc_en,
  output logic [1:0]   sc_dw,
  input  logic         sc_done,
  input  logic [159:0] sc_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GUARD   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 2);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [2:0]    RETRY_MAX  = 3'(MAX_RETRY);

  logic [2:0]    state_reg;
  logic [TW-1:0] timer_reg;
  logic [GW-1:0] guard_cnt_reg;
  logic          busy_reg, done_reg, err_reg, data_valid_reg, sc_en_reg;
  logic [1:0]    err_code_reg, sc_dw_reg;
  logic [2:0]    retry_cnt_reg;
  logic [159:0]  data_out_reg;
  logic          start_int;

`ifdef SIM_SEQ_POLL_EN
  localparam int PW = $clog2(POLL_CYCLES + 2);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES);

  logic [PW-1:0] poll_cnt_reg;
  logic          poll_start;

  assign poll_start = (state_reg == S_IDLE) && poll_en && (poll_cnt_reg == '0);
  assign start_int  = start | poll_start;

  // Reload on any accepted start and while polling is disabled; count only in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_reg <= '0;
    end else if (!poll_en || ((state_reg == S_IDLE) && start_int)) begin
      poll_cnt_reg <= POLL_LOAD;
    end else if ((state_reg == S_IDLE) && (poll_cnt_reg != '0)) begin
      poll_cnt_reg <= poll_cnt_reg - PW'(1);
    end
  end
`else
  assign start_int = start;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      timer_reg      <= '0;
      guard_cnt_reg  <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= 2'b00;
      retry_cnt_reg  <= 3'd0;
      data_valid_reg <= 1'b0;
      data_out_reg   <= '0;
      sc_en_reg      <= 1'b0;
      sc_dw_reg      <= 2'b00;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == S_IDLE) begin
        if (start_int) begin
          sc_dw_reg      <= dw_in;
          retry_cnt_reg  <= 3'd0;
          busy_reg       <= 1'b1;
          err_reg        <= 1'b0;
          err_code_reg   <= 2'b00;
          data_valid_reg <= 1'b0;
          guard_cnt_reg  <= GUARD_LOAD;
          timer_reg      <= TIMER_LOAD;
          state_reg      <= S_GUARD;
        end
      end else if (abort) begin
        // Abort takes priority over any completion or timeout seen this cycle.
        sc_en_reg    <= 1'b0;
        err_reg      <= 1'b1;
        err_code_reg <= 2'b11;
        busy_reg     <= 1'b0;
        done_reg     <= 1'b1;
        state_reg    <= S_IDLE;
      end else begin
        case (state_reg)
          S_GUARD: begin
            sc_en_reg <= 1'b0;
            if (guard_cnt_reg != '0) begin
              guard_cnt_reg <= guard_cnt_reg - GW'(1);
            end else if (!sc_done) begin
              sc_en_reg <= 1'b1;
              timer_reg <= TIMER_LOAD;
              state_reg <= S_WAIT;
            end else if (timer_reg == '0) begin
              err_code_reg <= 2'b01;
              state_reg    <= S_FAIL;
            end else begin
              timer_reg <= timer_reg - TW'(1);
            end
          end
          S_WAIT: begin
            if (sc_done) begin
              data_out_reg   <= sc_data;
              data_valid_reg <= 1'b1;
              sc_en_reg      <= 1'b0;
              timer_reg      <= TIMER_LOAD;
              state_reg      <= S_RELEASE;
            end else if (timer_reg == '0) begin
              sc_en_reg <= 1'b0;
              if (retry_cnt_reg < RETRY_MAX) begin
                retry_cnt_reg <= retry_cnt_reg + 3'd1;
                guard_cnt_reg <= GUARD_LOAD;
                timer_reg     <= TIMER_LOAD;
                state_reg     <= S_GUARD;
              end else begin
                err_code_reg <= 2'b10;
                state_reg    <= S_FAIL;
              end
            end else begin
              timer_reg <= timer_reg - TW'(1);
            end
          end
          S_RELEASE: begin
            if (!sc_done) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else if (timer_reg == '0) begin
              err_code_reg <= 2'b01;
              state_reg    <= S_FAIL;
            end else begin
              timer_reg <= timer_reg - TW'(1);
            end
          end
          S_FAIL: begin
            sc_en_reg <= 1'b0;
            err_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign err_code   = err_code_reg;
  assign retry_cnt  = retry_cnt_reg;
  assign data_valid = data_valid_reg;
  assign data_out   = data_out_reg;
  assign sc_en      = sc_en_reg;
  assign sc_dw      = sc_dw_reg;

endmodule

// File: tb/tb_sim_read_sequencer.sv
// Scoreboard bench for sim_read_sequencer with a behavioural Main_SIM responder.
module tb_sim_read_sequencer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   dw_in = 2'd0;
`ifdef SIM_SEQ_POLL_EN
  logic         poll_en = 1'b0;
`endif
  logic         busy, done, err, data_valid, sc_en;
  logic [1:0]   err_code, sc_dw;
  logic [2:0]   retry_cnt;
  logic [159:0] data_out;
  logic         sc_done = 1'b0;
  logic [159:0] sc_data = '0;

  sim_read_sequencer #(
    .GUARD_CYCLES(4), .TIMEOUT_CYCLES(100), .MAX_RETRY(2), .POLL_CYCLES(300)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .dw_in(dw_in),
`ifdef SIM_SEQ_POLL_EN
    .poll_en(poll_en),
`endif
    .busy(busy), .done(done), .err(err), .err_code(err_code), .retry_cnt(retry_cnt),
    .data_valid(data_valid), .data_out(data_out), .sc_en(sc_en), .sc_dw(sc_dw),
    .sc_done(sc_done), .sc_data(sc_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         err;
    logic [1:0]   code;
    logic [2:0]   retry;
    logic         dv;
    logic [159:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   txn = 0;
  int   en_rises = 0;
  logic en_prev = 1'b0;
  logic model_silent = 1'b0;
  logic model_stuck = 1'b0;
  logic [159:0] data_a, data_b;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Main_SIM model: raises Hecho 10 cycles after Habilitar rises, drops it when Habilitar falls.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (model_stuck) begin
        sc_done = 1'b1;
      end else if (!sc_en) begin
        cnt = 0;
        sc_done = 1'b0;
      end else if (!model_silent) begin
        cnt++;
        if (cnt == 10) sc_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sc_en && !en_prev) en_rises++;
      en_prev = sc_en;
    end
  end

  // Monitor: every done pulse pops one expected completion record.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && done) begin
        exp_t e;
        txn++;
        $display("txn %0d: err=%0b code=%0b retry=%0d dv=%0b data=%0h",
                 txn, err, err_code, retry_cnt, data_valid, data_out);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 160'(done), 160'(0));
        end else begin
          e = exp_q.pop_front();
          check("err", 160'(err), 160'(e.err));
          check("err_code", 160'(err_code), 160'(e.code));
          check("retry_cnt", 160'(retry_cnt), 160'(e.retry));
          check("data_valid", 160'(data_valid), 160'(e.dv));
          check("data_out", data_out, e.data);
          check("busy_at_done", 160'(busy), 160'(0));
        end
      end
    end
  end

  task automatic do_start(input logic [1:0] dw, input logic with_abort);
    @(negedge clk);
    dw_in = dw;
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", 160'(busy), 160'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!sc_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("en_bound", 160'(sc_en), 160'(1));
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, 160'({busy, done, err, err_code, retry_cnt, data_valid, sc_en, sc_dw}), 160'(0));
    check({name, "_data"}, data_out, 160'(0));
  endtask

  initial begin
    data_a = {{19{8'hA5}}, 8'h5A};
    data_b = {40{4'h3}} ^ {{159{1'b0}}, 1'b1};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1. quiet after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_reset_outputs("reset_idle");
    end

    // 2. successful read, sc_en rises at edge GUARD+1
    sc_data = data_a;
    en_rises = 0;
    exp_q.push_back('{err: 1'b0, code: 2'b00, retry: 3'd0, dv: 1'b1, data: data_a});
    do_start(2'd2, 1'b0);
    check("busy_after_start", 160'(busy), 160'(1));
    check("sc_dw", 160'(sc_dw), 160'(2));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("sc_en_guard", 160'(sc_en), 160'(0));
    end
    @(negedge clk);
    check("sc_en_edge5", 160'(sc_en), 160'(1));
    wait_idle();
    check("en_rises_ok", 160'(en_rises), 160'(1));

    // 3. silent model: three attempts then no-response failure
    model_silent = 1'b1;
    en_rises = 0;
    exp_q.push_back('{err: 1'b1, code: 2'b10, retry: 3'd2, dv: 1'b0, data: data_a});
    do_start(2'd1, 1'b0);
    wait_idle();
    check("en_rises_retry", 160'(en_rises), 160'(3));
    model_silent = 1'b0;

    // 4. done stuck high: enable never asserted
    model_stuck = 1'b1;
    repeat (2) @(negedge clk);
    en_rises = 0;
    exp_q.push_back('{err: 1'b1, code: 2'b01, retry: 3'd0, dv: 1'b0, data: data_a});
    do_start(2'd0, 1'b0);
    wait_idle();
    check("en_rises_stuck", 160'(en_rises), 160'(0));
    model_stuck = 1'b0;
    repeat (3) @(negedge clk);

    // 5. abort 3 cycles into WAIT; capture must not happen
    sc_data = data_b;
    exp_q.push_back('{err: 1'b1, code: 2'b11, retry: 3'd0, dv: 1'b0, data: data_a});
    do_start(2'd3, 1'b0);
    wait_en();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_sc_en", 160'(sc_en), 160'(0));
    check("abort_done", 160'(done), 160'(1));
    wait_idle();

    // start+abort in IDLE is accepted; a start while busy is dropped
    exp_q.push_back('{err: 1'b0, code: 2'b00, retry: 3'd0, dv: 1'b1, data: data_b});
    do_start(2'd1, 1'b1);
    check("start_abort_busy", 160'(busy), 160'(1));
    repeat (3) @(negedge clk);
    do_start(2'd3, 1'b0);
    check("sc_dw_hold", 160'(sc_dw), 160'(1));
    wait_idle();
    repeat (10) @(negedge clk);
    check("no_second_txn", 160'(busy), 160'(0));

    // 6. asynchronous reset mid-WAIT
    do_start(2'd2, 1'b0);
    wait_en();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_sc_en", 160'(sc_en), 160'(0));
    check("async_busy", 160'(busy), 160'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    repeat (5) @(negedge clk);
    check("queue_empty", 160'(exp_q.size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
